tx_queue: RTL and testbench

TX_QUEUE -- requirements
Module: tx_queue

---
 rtl/uart_pkg.sv | 20 ++
 rtl/tx_queue_mem.sv | 33 +++
 rtl/tx_queue.sv | 161 ++++++++++++++++
 tb/tb_tx_queue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default sizes for the UART transmit path.
// Holds the tx_queue drain FSM state encoding and the default queue
// depth / data width used by tx_queue and tx_queue_mem.
`timescale 1ns/1ps

package uart_pkg;

    localparam int TXQ_DEPTH  = 16;
    localparam int UART_WIDTH = 8;

    // Drain FSM: IDLE waits for data, LOAD strobes one byte into uart_tx,
    // BUSY waits for the transmitter to finish, GAP swallows a long done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } tx_queue_state_t;

endpackage

// File: rtl/tx_queue_mem.sv
// tx_queue_mem: byte storage for tx_queue.
// One synchronous write port and one asynchronous read port that always
// presents the entry at the read address (the queue head). Contents are
// not reset; the pointers in tx_queue decide what is valid.
`timescale 1ns/1ps

module tx_queue_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = TXQ_DEPTH,
    parameter  int WIDTH = UART_WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming byte into its slot on an accepted push.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/tx_queue.sv
// tx_queue: byte FIFO in front of uart_tx with a four-state drain FSM.
// A producer pushes bytes with one-cycle i_dv strobes; the FSM hands
// them one at a time to uart_tx (o_tx_dv/o_tx_byte) and waits for
// i_tx_done between bytes. DEPTH must be a power of two, at least 2.
// Pointers carry one extra MSB so full and empty are distinguishable;
// occupancy is the pointer difference.
// Optional feature: define TX_QUEUE_OVF_COUNT_EN to add o_ovf_count,
// a saturating 16-bit count of dropped writes (cleared only by reset).
// Handshake: a write is accepted on any edge where i_dv=1, the queue is
// not full at the start of the cycle and i_flush=0; a pop in that same
// cycle does not free space. o_tx_dv is a one-cycle start strobe and
// the byte is considered in flight until uart_tx reports i_tx_done.
`timescale 1ns/1ps

module tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH = TXQ_DEPTH,
    parameter  int WIDTH = UART_WIDTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            i_dv,
    input  logic [WIDTH-1:0] i_byte,
    input  logic            i_flush,
    input  logic            i_tx_active,
    input  logic            i_tx_done,
    output logic            o_tx_dv,
    output logic [WIDTH-1:0] o_tx_byte,
    output logic            o_full,
    output logic            o_empty,
    output logic [CW-1:0]   o_count,
    output logic            o_overflow,
`ifdef TX_QUEUE_OVF_COUNT_EN
    output logic [15:0]     o_ovf_count,
`endif
    output tx_queue_state_t o_dbg_state
);

    localparam int            AW      = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);

    tx_queue_state_t  state_q, state_d;
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic             overflow_q, overflow_d;

    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] head;

    // Occupancy and the push/pop/drop decisions for this cycle.
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        full  = (count == DEPTH_C);
        empty = (count == '0);
        pop   = (state_q == LOAD);
        push  = i_dv && !full && !i_flush;
        drop  = i_dv && full && !i_flush;
    end

    // Pointer update; flush clears both and overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Drain FSM next state; the head byte is captured on entry to LOAD.
    always_comb begin
        state_d    = state_q;
        tx_byte_d  = tx_byte_q;
        overflow_d = drop;
        case (state_q)
            IDLE: begin
                if (!empty && !i_tx_active && !i_flush) begin
                    state_d   = LOAD;
                    tx_byte_d = head;
                end
            end
            LOAD:    state_d = BUSY;
            BUSY:    if (i_tx_done) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_byte_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
        end
    end

    tx_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (push),
        .i_waddr (wr_ptr_q[AW-1:0]),
        .i_wdata (i_byte),
        .i_raddr (rd_ptr_q[AW-1:0]),
        .o_rdata (head)
    );

`ifdef TX_QUEUE_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of dropped writes; flush leaves it alone.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Dropped-write counter register, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ovf_count = ovf_cnt_q;
`endif

    assign o_tx_dv     = (state_q == LOAD);
    assign o_tx_byte   = tx_byte_q;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_count     = count;
    assign o_overflow  = overflow_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tx_queue.sv
// tb_tx_queue: directed bench for tx_queue (DEPTH=4, WIDTH=8).
// Inputs change on the falling edge; outputs are checked on the falling
// edge, half a cycle after the rising edge that produced them.
`timescale 1ns/1ps

module tb_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             i_dv;
    logic [WIDTH-1:0] i_byte;
    logic             i_flush;
    logic             i_tx_active;
    logic             i_tx_done;
    logic             o_tx_dv;
    logic [WIDTH-1:0] o_tx_byte;
    logic             o_full;
    logic             o_empty;
    logic [CW-1:0]    o_count;
    logic             o_overflow;
    tx_queue_state_t  o_dbg_state;
`ifdef TX_QUEUE_OVF_COUNT_EN
    logic [15:0]      o_ovf_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_b;

    // clock / reset
    always #5 clk = ~clk;

    tx_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_dv        (i_dv),
        .i_byte      (i_byte),
        .i_flush     (i_flush),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
`ifdef TX_QUEUE_OVF_COUNT_EN
        .o_ovf_count (o_ovf_count),
`endif
        .o_dbg_state (o_dbg_state)
    );

    // driver tasks
    task automatic tick;
        @(negedge clk);
    endtask

    // Model of uart_tx: active for 'busy' cycles, then done held 'done_len' cycles.
    task automatic run_tx(input int busy, input int done_len);
        i_tx_active = 1'b1;
        repeat (busy) tick;
        i_tx_active = 1'b0;
        i_tx_done   = 1'b1;
        repeat (done_len) tick;
        i_tx_done   = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) tick;
        n_cmp++; if (o_dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", o_dbg_state, IDLE); end
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", o_full); end
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL rst_tx_dv: got %b want 0", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_tx_byte: got %h want 00", o_tx_byte); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", o_overflow); end
`ifdef TX_QUEUE_OVF_COUNT_EN
        n_cmp++; if (o_ovf_count !== 16'd0) begin n_bad++; $display("FAIL rst_ovf_count: got %0d want 0", o_ovf_count); end
`endif
        n_rst = 1'b1;
        tick;
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL rst_release_dv: got %b want 0", o_tx_dv); end
    endtask

    task automatic test_single;
        i_dv = 1'b1; i_byte = 8'h41;
        tick;
        i_dv = 1'b0;
        n_cmp++; if (o_count !== 3'd1) begin n_bad++; $display("FAIL single_count1: got %0d want 1", o_count); end
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL single_dv_early: got %b want 0", o_tx_dv); end
        tick;
        n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL single_dv: got %b want 1", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== 8'h41) begin n_bad++; $display("FAIL single_byte: got %h want 41", o_tx_byte); end
        tick;
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL single_dv_pulse: got %b want 0", o_tx_dv); end
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL single_count0: got %0d want 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL single_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_dbg_state !== BUSY) begin n_bad++; $display("FAIL single_busy: got %0d want %0d", o_dbg_state, BUSY); end
        run_tx(3, 1);
        n_cmp++; if (o_dbg_state !== GAP) begin n_bad++; $display("FAIL single_gap: got %0d want %0d", o_dbg_state, GAP); end
        n_cmp++; if (o_tx_byte !== 8'h41) begin n_bad++; $display("FAIL single_byte_hold: got %h want 41", o_tx_byte); end
        tick;
        n_cmp++; if (o_dbg_state !== IDLE) begin n_bad++; $display("FAIL single_idle: got %0d want %0d", o_dbg_state, IDLE); end
    endtask

    task automatic test_active_block;
        i_tx_active = 1'b1;
        i_dv = 1'b1; i_byte = 8'h33;
        tick;
        i_dv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL active_no_load%0d: got %b want 0", k, o_tx_dv); end
        end
        n_cmp++; if (o_count !== 3'd1) begin n_bad++; $display("FAIL active_count: got %0d want 1", o_count); end
        i_tx_active = 1'b0;
        tick;
        n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL active_load: got %b want 1", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== 8'h33) begin n_bad++; $display("FAIL active_byte: got %h want 33", o_tx_byte); end
        tick;
        run_tx(1, 1);
        tick;
    endtask

    task automatic test_burst;
        i_dv = 1'b1; i_byte = 8'h70; exp_q.push_back(8'h70);
        tick;
        i_byte = 8'h62; exp_q.push_back(8'h62);
        tick;
        exp_b = exp_q.pop_front();
        n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL burst_dv0: got %b want 1", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== exp_b) begin n_bad++; $display("FAIL burst_byte0: got %h want %h", o_tx_byte, exp_b); end
        i_byte = 8'h63; exp_q.push_back(8'h63);
        tick;
        i_dv = 1'b0;
        n_cmp++; if (o_count !== 3'd2) begin n_bad++; $display("FAIL burst_pushpop_count: got %0d want 2", o_count); end
        for (int k = 1; k < 3; k++) begin
            run_tx(2, 1);
            n_cmp++; if (o_dbg_state !== GAP) begin n_bad++; $display("FAIL burst_gap%0d: got %0d want %0d", k, o_dbg_state, GAP); end
            tick;
            n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL burst_idle_dv%0d: got %b want 0", k, o_tx_dv); end
            tick;
            exp_b = exp_q.pop_front();
            n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL burst_dv%0d: got %b want 1", k, o_tx_dv); end
            n_cmp++; if (o_tx_byte !== exp_b) begin n_bad++; $display("FAIL burst_byte%0d: got %h want %h", k, o_tx_byte, exp_b); end
            tick;
        end
        run_tx(2, 1);
        tick;
        tick;
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL burst_end_dv: got %b want 0", o_tx_dv); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL burst_end_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_overflow;
        i_tx_active = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_dv = 1'b1; i_byte = 8'hA0 + 8'(k);
            if (k < 4) exp_q.push_back(8'hA0 + 8'(k));
            tick;
            n_cmp++; if (o_count !== ((k < 4) ? 3'(k + 1) : 3'd4)) begin n_bad++; $display("FAIL ovf_count_k%0d: got %0d want %0d", k, o_count, (k < 4) ? k + 1 : 4); end
            n_cmp++; if (o_full !== (k >= 3)) begin n_bad++; $display("FAIL ovf_full_k%0d: got %b want %b", k, o_full, (k >= 3)); end
            n_cmp++; if (o_overflow !== (k == 4)) begin n_bad++; $display("FAIL ovf_pulse_k%0d: got %b want %b", k, o_overflow, (k == 4)); end
        end
        i_dv = 1'b0;
        tick;
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse_end: got %b want 0", o_overflow); end
`ifdef TX_QUEUE_OVF_COUNT_EN
        n_cmp++; if (o_ovf_count !== 16'd1) begin n_bad++; $display("FAIL ovf_cnt1: got %0d want 1", o_ovf_count); end
`endif
        i_tx_active = 1'b0;
        tick;
        exp_b = exp_q.pop_front();
        n_cmp++; if (o_tx_byte !== exp_b) begin n_bad++; $display("FAIL ovf_drain_byte0: got %h want %h", o_tx_byte, exp_b); end
        // write during the LOAD pop while full: must still be dropped
        i_dv = 1'b1; i_byte = 8'hEE;
        tick;
        i_dv = 1'b0;
        n_cmp++; if (o_count !== 3'd3) begin n_bad++; $display("FAIL ovf_pop_noroom_count: got %0d want 3", o_count); end
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pop_noroom_pulse: got %b want 1", o_overflow); end
`ifdef TX_QUEUE_OVF_COUNT_EN
        n_cmp++; if (o_ovf_count !== 16'd2) begin n_bad++; $display("FAIL ovf_cnt2: got %0d want 2", o_ovf_count); end
`endif
        for (int k = 1; k < 4; k++) begin
            run_tx(1, 1);
            tick;
            tick;
            exp_b = exp_q.pop_front();
            n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL ovf_drain_dv%0d: got %b want 1", k, o_tx_dv); end
            n_cmp++; if (o_tx_byte !== exp_b) begin n_bad++; $display("FAIL ovf_drain_byte%0d: got %h want %h", k, o_tx_byte, exp_b); end
            tick;
        end
        run_tx(1, 1);
        tick;
        tick;
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drain_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL ovf_no_extra_load: got %b want 0", o_tx_dv); end
    endtask

    task automatic test_done_hold;
        i_dv = 1'b1; i_byte = 8'h11;
        tick;
        i_byte = 8'h22;
        tick;
        i_dv = 1'b0;
        n_cmp++; if (o_tx_byte !== 8'h11) begin n_bad++; $display("FAIL done_byte0: got %h want 11", o_tx_byte); end
        tick;
        run_tx(2, 2);
        n_cmp++; if (o_dbg_state !== IDLE) begin n_bad++; $display("FAIL done_hold_state: got %0d want %0d", o_dbg_state, IDLE); end
        n_cmp++; if (o_count !== 3'd1) begin n_bad++; $display("FAIL done_hold_count: got %0d want 1", o_count); end
        tick;
        n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL done_next_dv: got %b want 1", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== 8'h22) begin n_bad++; $display("FAIL done_next_byte: got %h want 22", o_tx_byte); end
        tick;
        run_tx(1, 1);
        tick;
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL done_end_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_flush;
        i_dv = 1'b1; i_byte = 8'hB1;
        tick;
        i_byte = 8'hB2;
        tick;
        i_dv = 1'b0;
        tick;
        n_cmp++; if (o_count !== 3'd1) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 1", o_count); end
        i_tx_active = 1'b1;
        i_flush = 1'b1; i_dv = 1'b1; i_byte = 8'hCC;
        tick;
        i_flush = 1'b0; i_dv = 1'b0;
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", o_count); end
        n_cmp++; if (o_dbg_state !== BUSY) begin n_bad++; $display("FAIL flush_keeps_busy: got %0d want %0d", o_dbg_state, BUSY); end
        n_cmp++; if (o_tx_byte !== 8'hB1) begin n_bad++; $display("FAIL flush_byte_hold: got %h want b1", o_tx_byte); end
        run_tx(1, 1);
        n_cmp++; if (o_dbg_state !== GAP) begin n_bad++; $display("FAIL flush_gap: got %0d want %0d", o_dbg_state, GAP); end
        for (int k = 0; k < 3; k++) begin
            tick;
            n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL flush_no_load%0d: got %b want 0", k, o_tx_dv); end
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 4; k++) begin
            i_dv = 1'b1; i_byte = 8'hD0 + 8'(k);
            tick;
        end
        i_dv = 1'b0;
        n_cmp++; if (o_dbg_state !== BUSY) begin n_bad++; $display("FAIL rmid_busy: got %0d want %0d", o_dbg_state, BUSY); end
        n_cmp++; if (o_count !== 3'd3) begin n_bad++; $display("FAIL rmid_count3: got %0d want 3", o_count); end
        i_tx_active = 1'b1;
        #1 n_rst = 1'b0;
        #1;
        n_cmp++; if (o_dbg_state !== IDLE) begin n_bad++; $display("FAIL rmid_state: got %0d want %0d", o_dbg_state, IDLE); end
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL rmid_dv: got %b want 0", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== 8'h00) begin n_bad++; $display("FAIL rmid_byte: got %h want 00", o_tx_byte); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow: got %b want 0", o_overflow); end
`ifdef TX_QUEUE_OVF_COUNT_EN
        n_cmp++; if (o_ovf_count !== 16'd0) begin n_bad++; $display("FAIL rmid_ovf_count: got %0d want 0", o_ovf_count); end
`endif
        tick;
        i_tx_active = 1'b0;
        tick;
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_cmp++; if (o_tx_dv !== 1'b0) begin n_bad++; $display("FAIL rmid_spurious%0d: got %b want 0", k, o_tx_dv); end
        end
        i_dv = 1'b1; i_byte = 8'h5A;
        tick;
        i_dv = 1'b0;
        tick;
        n_cmp++; if (o_tx_dv !== 1'b1) begin n_bad++; $display("FAIL rmid_new_dv: got %b want 1", o_tx_dv); end
        n_cmp++; if (o_tx_byte !== 8'h5A) begin n_bad++; $display("FAIL rmid_new_byte: got %h want 5a", o_tx_byte); end
        tick;
        run_tx(1, 1);
        tick;
    endtask

    // sequence and final report
    initial begin
        n_rst = 1'b0; i_dv = 1'b0; i_byte = '0; i_flush = 1'b0;
        i_tx_active = 1'b0; i_tx_done = 1'b0;
        test_reset;
        test_single;
        test_active_block;
        test_burst;
        test_overflow;
        test_done_hold;
        test_flush;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
